// File: rtl/qspi_rx_word_assembler_pkg.sv
// Shared QSPI receive types and helpers: FSM states, lane modes,
// lane decode (also used by the sampling register) and byte swap.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CAPTURE,
    DRAIN,
    DONE
  } rx_asm_state_t;

  typedef enum logic [1:0] {
    LANE_1,
    LANE_2,
    LANE_4,
    LANE_NONE
  } lane_mode_t;

  // Widest lane mode wins when several are set.
  function automatic lane_mode_t lane_decode(
    input logic u1,
    input logic u2,
    input logic u4
  );
    lane_mode_t m;
    if (u4)      m = LANE_4;
    else if (u2) m = LANE_2;
    else if (u1) m = LANE_1;
    else         m = LANE_NONE;
    return m;
  endfunction

  function automatic logic [5:0] lane_bits(input lane_mode_t m);
    logic [5:0] b;
    unique case (m)
      LANE_4:  b = 6'd4;
      LANE_2:  b = 6'd2;
      LANE_1:  b = 6'd1;
      default: b = 6'd0;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_rx_word_assembler_if.sv
// Word handshake towards the RX FIFO.
// master: drives word_valid/word_data/word_bytes, receives word_ready.
interface qspi_rx_word_assembler_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;

  modport master (
    output word_valid,
    output word_data,
    output word_bytes,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  word_bytes,
    output word_ready
  );
endinterface

// File: rtl/qspi_rx_word_assembler.sv
// QSPI read-data word assembler: counts samples per lane mode, captures
// left-justified (optionally byte-swapped) words and offers them to the
// RX FIFO. Ports: clk, rst (sync, high), xfer_start/abort/len, lane mode
// inputs, sample_en/sample_data, wif (master handshake), busy, xfer_done,
// overrun.
module qspi_rx_word_assembler
  import qspi_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_start,
  input  logic             xfer_abort,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             use_1_io_lines_in,
  input  logic             use_2_io_lines_in,
  input  logic             use_4_io_lines_in,
  input  logic             sample_en,
  input  logic [31:0]      sample_data,
  qspi_rx_word_assembler_if.master wif,
  output logic             busy,
  output logic             xfer_done,
  output logic             overrun
);

  rx_asm_state_t    state_q, state_d;
  lane_mode_t       lane_q, lane_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       nb_q, nb_d;
  logic             ovr_q, ovr_d;

  logic [5:0]  bps;
  logic [5:0]  sum;
  logic [2:0]  n;
  logic [2:0]  pad;
  logic [5:0]  target;
  logic [31:0] w_sh;
  logic [31:0] w_new;

  assign bps    = lane_bits(lane_q);
  assign sum    = cnt_q + bps;
  assign n      = (left_q >= LEN_W'(4)) ? 3'd4 : left_q[2:0];
  assign pad    = 3'd4 - n;
  assign target = {n, 3'b000};
  assign w_sh   = sample_data << {pad, 3'b000};
  assign w_new  = BYTE_SWAP ? byte_swap32(w_sh) : w_sh;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    data_d  = data_q;
    nb_d    = nb_q;
    ovr_d   = ovr_q;

    if (vld_q && wif.word_ready) vld_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer_start) begin
          lane_d  = lane_decode(use_1_io_lines_in,
                                use_2_io_lines_in,
                                use_4_io_lines_in);
          left_d  = xfer_len;
          cnt_d   = 6'd0;
          ovr_d   = 1'b0;
          state_d = (xfer_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample_en && bps != 6'd0) begin
          if (sum == target) begin
            cnt_d   = 6'd0;
            state_d = CAPTURE;
          end else begin
            cnt_d = sum;
          end
        end
      end
      CAPTURE: begin
        // A word still waiting (not taken this cycle) blocks the new one.
        if (vld_q && !wif.word_ready) begin
          ovr_d = 1'b1;
        end else begin
          vld_d  = 1'b1;
          data_d = w_new;
          nb_d   = n;
        end
        left_d = left_q - LEN_W'(n);
        // Flash keeps clocking: a sample here starts the next word.
        cnt_d   = (sample_en) ? bps : 6'd0;
        state_d = (left_q == LEN_W'(n)) ? DRAIN : RUN;
      end
      DRAIN: begin
        if (!vld_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer_abort) begin
      state_d = IDLE;
      lane_d  = lane_q;
      left_d  = '0;
      cnt_d   = 6'd0;
      vld_d   = 1'b0;
      ovr_d   = ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= LANE_NONE;
      left_q  <= '0;
      cnt_q   <= 6'd0;
      vld_q   <= 1'b0;
      data_q  <= 32'd0;
      nb_q    <= 3'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      nb_q    <= nb_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wif.word_valid = vld_q;
  assign wif.word_data  = data_q;
  assign wif.word_bytes = nb_q;
  assign busy           = (state_q != IDLE);
  assign xfer_done      = (state_q == DONE);
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_qspi_rx_word_assembler.sv
// Directed testbench for qspi_rx_word_assembler (swap and no-swap
// instances sharing stimulus).
module tb_qspi_rx_word_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        xfer_start;
  logic        xfer_abort;
  logic [15:0] xfer_len;
  logic        u1, u2, u4;
  logic        sample_en;
  logic [31:0] sample_data = 32'd0;
  logic        ready;
  logic        busy, xfer_done, overrun;
  logic        busy2, done2, ovr2;

  int total = 0;
  int bad   = 0;

  logic [3:0]  sbits;
  int          mode_bits;
  logic [7:0]  bq [8];
  logic [31:0] got_data [$];
  logic [2:0]  got_bytes [$];

  always #5 clk = ~clk;

  qspi_rx_word_assembler_if wif ();
  qspi_rx_word_assembler_if wif2 ();
  assign wif.word_ready  = ready;
  assign wif2.word_ready = ready;

  qspi_rx_word_assembler #(.LEN_W(16), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .xfer_start(xfer_start), .xfer_abort(xfer_abort),
    .xfer_len(xfer_len),
    .use_1_io_lines_in(u1), .use_2_io_lines_in(u2),
    .use_4_io_lines_in(u4),
    .sample_en(sample_en), .sample_data(sample_data),
    .wif(wif),
    .busy(busy), .xfer_done(xfer_done), .overrun(overrun)
  );

  qspi_rx_word_assembler #(.LEN_W(16), .BYTE_SWAP(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .xfer_start(xfer_start), .xfer_abort(xfer_abort),
    .xfer_len(xfer_len),
    .use_1_io_lines_in(u1), .use_2_io_lines_in(u2),
    .use_4_io_lines_in(u4),
    .sample_en(sample_en), .sample_data(sample_data),
    .wif(wif2),
    .busy(busy2), .xfer_done(done2), .overrun(ovr2)
  );

  // Sampling register: shifts lane bits in MSB-first on sample_en.
  always @(posedge clk) begin
    if (sample_en)
      sample_data <= (sample_data << mode_bits) | {28'd0, sbits};
    if (wif.word_valid && wif.word_ready) begin
      got_data.push_back(wif.word_data);
      got_bytes.push_back(wif.word_bytes);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int b);
    u1 = (b == 1);
    u2 = (b == 2);
    u4 = (b == 4);
    mode_bits = b;
  endtask

  task automatic start(input int len);
    xfer_len   = 16'(len);
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic feed(input int nsamp);
    int g;
    for (int k = 0; k < nsamp; k++) begin
      g = k * mode_bits;
      sbits = 4'd0;
      for (int j = 0; j < mode_bits; j++)
        sbits = {sbits[2:0], bq[(g + j) / 8][7 - ((g + j) % 8)]};
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    sbits = 4'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (wif.word_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", wif.word_valid);
    end
    total++;
    if (wif.word_data !== 32'd0 || wif.word_bytes !== 3'd0) begin
      bad++; $display("FAIL rst_data got=%h/%0d exp=0/0",
                      wif.word_data, wif.word_bytes);
    end
    total++;
    if ({busy, xfer_done, overrun} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000",
                      {busy, xfer_done, overrun});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_quad;
    set_mode(4);
    ready = 1'b1;
    bq[0] = 8'h12; bq[1] = 8'h34; bq[2] = 8'h56; bq[3] = 8'h78;
    start(4);
    feed(8);
    total++;
    if (wif.word_valid !== 1'b0) begin
      bad++; $display("FAIL quad_capture_valid got=%b exp=0",
                      wif.word_valid);
    end
    tick();
    total++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== 32'h78563412) begin
      bad++; $display("FAIL quad_word got=%b/%h exp=1/78563412",
                      wif.word_valid, wif.word_data);
    end
    total++;
    if (wif.word_bytes !== 3'd4) begin
      bad++; $display("FAIL quad_bytes got=%0d exp=4", wif.word_bytes);
    end
    total++;
    if (wif2.word_data !== 32'h12345678) begin
      bad++; $display("FAIL quad_noswap got=%h exp=12345678",
                      wif2.word_data);
    end
    tick();
    total++;
    if (wif.word_valid !== 1'b0 || xfer_done !== 1'b0) begin
      bad++; $display("FAIL quad_after_accept got=%b%b exp=00",
                      wif.word_valid, xfer_done);
    end
    tick();
    total++;
    if (xfer_done !== 1'b1) begin
      bad++; $display("FAIL quad_done got=%b exp=1", xfer_done);
    end
    tick();
    total++;
    if (xfer_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL quad_idle got=%b%b exp=00", xfer_done, busy);
    end
  endtask

  task automatic test_single;
    set_mode(1);
    ready = 1'b1;
    bq[0] = 8'hA5;
    start(1);
    feed(8);
    tick();
    total++;
    if (wif.word_data !== 32'h000000A5 || wif.word_bytes !== 3'd1) begin
      bad++; $display("FAIL single_swap got=%h/%0d exp=000000a5/1",
                      wif.word_data, wif.word_bytes);
    end
    total++;
    if (wif2.word_data !== 32'hA5000000 || wif2.word_bytes !== 3'd1) begin
      bad++; $display("FAIL single_noswap got=%h/%0d exp=a5000000/1",
                      wif2.word_data, wif2.word_bytes);
    end
    tick();
    tick();
    total++;
    if (xfer_done !== 1'b1) begin
      bad++; $display("FAIL single_done got=%b exp=1", xfer_done);
    end
    tick();
  endtask

  task automatic test_dual;
    int cyc;
    set_mode(2);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) bq[i] = 8'(i + 1);
    got_data.delete();
    got_bytes.delete();
    start(6);
    feed(24);
    cyc = 0;
    while (xfer_done !== 1'b1 && cyc < 12) begin
      tick();
      cyc++;
    end
    total++;
    if (xfer_done !== 1'b1) begin
      bad++; $display("FAIL dual_done_timeout got=%b exp=1", xfer_done);
    end
    total++;
    if (got_data.size() != 2) begin
      bad++; $display("FAIL dual_count got=%0d exp=2", got_data.size());
    end
    if (got_data.size() >= 1) begin
      total++;
      if (got_data[0] !== 32'h04030201 || got_bytes[0] !== 3'd4) begin
        bad++; $display("FAIL dual_w0 got=%h/%0d exp=04030201/4",
                        got_data[0], got_bytes[0]);
      end
    end
    if (got_data.size() >= 2) begin
      total++;
      if (got_data[1] !== 32'h00000605 || got_bytes[1] !== 3'd2) begin
        bad++; $display("FAIL dual_w1 got=%h/%0d exp=00000605/2",
                        got_data[1], got_bytes[1]);
      end
    end
    tick();
  endtask

  task automatic test_overrun;
    set_mode(4);
    ready = 1'b0;
    for (int i = 0; i < 8; i++) bq[i] = 8'h11 + 8'(i);
    start(8);
    feed(16);
    tick();
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_flag got=%b exp=1", overrun);
    end
    total++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== 32'h14131211) begin
      bad++; $display("FAIL ovr_held got=%b/%h exp=1/14131211",
                      wif.word_valid, wif.word_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (busy !== 1'b1 || xfer_done !== 1'b0 ||
          wif.word_data !== 32'h14131211) begin
        bad++; $display("FAIL ovr_drain got=%b%b/%h exp=10/14131211",
                        busy, xfer_done, wif.word_data);
      end
    end
    ready = 1'b1;
    tick();
    total++;
    if (wif.word_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_accept got=%b exp=0", wif.word_valid);
    end
    tick();
    total++;
    if (xfer_done !== 1'b1 || overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_done got=%b%b exp=11", xfer_done, overrun);
    end
    tick();
  endtask

  task automatic test_len0_busy_start;
    ready = 1'b1;
    set_mode(4);
    start(0);
    total++;
    if (xfer_done !== 1'b1 || busy !== 1'b1 || wif.word_valid !== 1'b0) begin
      bad++; $display("FAIL len0_done got=%b%b%b exp=110",
                      xfer_done, busy, wif.word_valid);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL len0_ovr_clear got=%b exp=0", overrun);
    end
    xfer_len = 16'd4;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    total++;
    if (busy !== 1'b0 || xfer_done !== 1'b0) begin
      bad++; $display("FAIL start_in_done got=%b%b exp=00", busy, xfer_done);
    end
    start(4);
    feed(3);
    xfer_len = 16'd0;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    total++;
    if (busy !== 1'b1 || xfer_done !== 1'b0) begin
      bad++; $display("FAIL start_in_run got=%b%b exp=10", busy, xfer_done);
    end
    tick();
    total++;
    if (xfer_done !== 1'b0) begin
      bad++; $display("FAIL start_in_run2 got=%b exp=0", xfer_done);
    end
    xfer_abort = 1'b1;
    tick();
    xfer_abort = 1'b0;
  endtask

  task automatic test_abort;
    int cyc;
    set_mode(4);
    ready = 1'b0;
    for (int i = 0; i < 8; i++) bq[i] = 8'h21 + 8'(i);
    start(8);
    feed(11);
    total++;
    if (wif.word_valid !== 1'b1) begin
      bad++; $display("FAIL abort_pending got=%b exp=1", wif.word_valid);
    end
    xfer_abort = 1'b1;
    tick();
    xfer_abort = 1'b0;
    total++;
    if (wif.word_valid !== 1'b0 || busy !== 1'b0 || xfer_done !== 1'b0) begin
      bad++; $display("FAIL abort_state got=%b%b%b exp=000",
                      wif.word_valid, busy, xfer_done);
    end
    tick();
    total++;
    if (xfer_done !== 1'b0) begin
      bad++; $display("FAIL abort_nodone got=%b exp=0", xfer_done);
    end
    ready = 1'b1;
    bq[0] = 8'hA1; bq[1] = 8'hB2; bq[2] = 8'hC3; bq[3] = 8'hD4;
    start(4);
    feed(8);
    tick();
    total++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== 32'hD4C3B2A1 ||
        wif.word_bytes !== 3'd4) begin
      bad++; $display("FAIL abort_restart got=%b/%h/%0d exp=1/d4c3b2a1/4",
                      wif.word_valid, wif.word_data, wif.word_bytes);
    end
    cyc = 0;
    while (xfer_done !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
    total++;
    if (xfer_done !== 1'b1) begin
      bad++; $display("FAIL abort_restart_done got=%b exp=1", xfer_done);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    xfer_start = 1'b0;
    xfer_abort = 1'b0;
    xfer_len   = 16'd0;
    sample_en  = 1'b0;
    sbits      = 4'd0;
    ready      = 1'b0;
    set_mode(0);
    for (int i = 0; i < 8; i++) bq[i] = 8'd0;
    test_reset();
    test_quad();
    test_single();
    test_dual();
    test_overrun();
    test_len0_busy_start();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
